// File: rtl/ycbcr2rgb565_if.sv
// Pixel-side bus of the YCbCr -> RGB565 converter: sync/pixel in, sync/pixel/clip statistics out.
interface ycbcr2rgb565_if #(
   parameter int unsigned CNT_W = 20
);
   logic             pre_frame_vsync;
   logic             pre_frame_hsync;
   logic             pre_frame_de;
   logic             gray_en;
   logic [7:0]       img_y;
   logic [7:0]       img_cb;
   logic [7:0]       img_cr;
   logic             post_frame_vsync;
   logic             post_frame_hsync;
   logic             post_frame_de;
   logic [15:0]      rgb565_out;
   logic [CNT_W-1:0] clip_count;
   logic             clip_count_valid;

   // Video source side: drives the YCbCr stream, observes the RGB stream.
   modport master (
      output pre_frame_vsync, pre_frame_hsync, pre_frame_de, gray_en,
      output img_y, img_cb, img_cr,
      input  post_frame_vsync, post_frame_hsync, post_frame_de,
      input  rgb565_out, clip_count, clip_count_valid
   );

   // Converter side.
   modport slave (
      input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, gray_en,
      input  img_y, img_cb, img_cr,
      output post_frame_vsync, post_frame_hsync, post_frame_de,
      output rgb565_out, clip_count, clip_count_valid
   );
endinterface

// File: rtl/ycbcr2rgb565.sv
// Four-stage YCbCr 4:4:4 -> RGB565 converter with gray mode, aligned sync delay
// and a per-frame clipped-pixel counter.
module ycbcr2rgb565 #(
   parameter int unsigned CNT_W = 20,
   parameter int unsigned LAT   = 4
) (
   input  logic          clk,
   input  logic          rst,
   ycbcr2rgb565_if.slave bus
);
   localparam int unsigned AW = 20;
   typedef logic signed [AW-1:0] acc_t;

   // S1: offset-removed chroma
   logic [7:0]        y1_q,  y1_d;
   logic signed [8:0] cb1_q, cb1_d;
   logic signed [8:0] cr1_q, cr1_d;
   logic              g1_q,  g1_d;

   // S2: products
   acc_t       yy2_q, yy2_d;
   acc_t       pr2_q, pr2_d;
   acc_t       pgb2_q, pgb2_d;
   acc_t       pgr2_q, pgr2_d;
   acc_t       pb2_q, pb2_d;
   logic [5:0] y2_q, y2_d;
   logic       g2_q, g2_d;
   acc_t       cb_ext, cr_ext;

   // S3: rounded sums
   acc_t       r3_q, r3_d;
   acc_t       gs3_q, gs3_d;
   acc_t       b3_q, b3_d;
   logic [5:0] y3_q, y3_d;
   logic       g3_q, g3_d;

   // S4: packed pixel and clip flag
   logic [15:0] rgb4_q, rgb4_d;
   logic        clip4_q, clip4_d;

   logic [LAT-1:0] vs_q, vs_d;
   logic [LAT-1:0] hs_q, hs_d;
   logic [LAT-1:0] de_q, de_d;

   logic             vs_prev_q, vs_prev_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_vld_q, cnt_vld_d;
   logic             vs_rise;
   logic             contrib;

   // Channel overflowed [0,255] before truncation to its packed width.
   function automatic logic chan_clip(input acc_t sum);
      acc_t sh;
      sh = sum >>> 8;
      return (sh < acc_t'(0)) || (sh > acc_t'(255));
   endfunction

   // Clamp-then-truncate to 5 bits equals clamping the sum shifted by 8+3.
   function automatic logic [4:0] chan5(input acc_t sum);
      acc_t sh;
      sh = sum >>> 11;
      if (sh < acc_t'(0))       return 5'd0;
      else if (sh > acc_t'(31)) return 5'h1F;
      else                      return sh[4:0];
   endfunction

   function automatic logic [5:0] chan6(input acc_t sum);
      acc_t sh;
      sh = sum >>> 10;
      if (sh < acc_t'(0))       return 6'd0;
      else if (sh > acc_t'(63)) return 6'h3F;
      else                      return sh[5:0];
   endfunction

   always_comb begin
      y1_d  = bus.img_y;
      cb1_d = $signed({1'b0, bus.img_cb}) - 9'sd128;
      cr1_d = $signed({1'b0, bus.img_cr}) - 9'sd128;
      g1_d  = bus.gray_en;

      cb_ext = acc_t'(cb1_q);
      cr_ext = acc_t'(cr1_q);
      yy2_d  = acc_t'({y1_q, 8'h00});
      pr2_d  = cr_ext * acc_t'(359);
      pgb2_d = cb_ext * acc_t'(88);
      pgr2_d = cr_ext * acc_t'(183);
      pb2_d  = cb_ext * acc_t'(454);
      y2_d   = y1_q[7:2];
      g2_d   = g1_q;

      r3_d  = yy2_q + pr2_q + acc_t'(128);
      gs3_d = yy2_q - pgb2_q - pgr2_q + acc_t'(128);
      b3_d  = yy2_q + pb2_q + acc_t'(128);
      y3_d  = y2_q;
      g3_d  = g2_q;

      if (g3_q) begin
         rgb4_d  = {y3_q[5:1], y3_q, y3_q[5:1]};
         clip4_d = 1'b0;
      end else begin
         rgb4_d  = {chan5(r3_q), chan6(gs3_q), chan5(b3_q)};
         clip4_d = chan_clip(r3_q) | chan_clip(gs3_q) | chan_clip(b3_q);
      end
   end

   // Sync delay lines sized to the pixel pipeline depth.
   always_comb begin
      vs_d = {vs_q[LAT-2:0], bus.pre_frame_vsync};
      hs_d = {hs_q[LAT-2:0], bus.pre_frame_hsync};
      de_d = {de_q[LAT-2:0], bus.pre_frame_de};
   end

   // Clip counter: a pixel coinciding with the vsync rise belongs to the new frame.
   always_comb begin
      vs_prev_d = vs_q[LAT-1];
      vs_rise   = vs_q[LAT-1] & ~vs_prev_q;
      contrib   = de_q[LAT-1] & clip4_q;
      cnt_d     = cnt_q;
      cnt_vld_d = 1'b0;
      acc_d     = acc_q;
      if (vs_rise) begin
         cnt_d     = acc_q;
         cnt_vld_d = 1'b1;
         acc_d     = CNT_W'(contrib);
      end else if (contrib && (acc_q != {CNT_W{1'b1}})) begin
         acc_d     = acc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y1_q      <= '0;
         cb1_q     <= '0;
         cr1_q     <= '0;
         g1_q      <= 1'b0;
         yy2_q     <= '0;
         pr2_q     <= '0;
         pgb2_q    <= '0;
         pgr2_q    <= '0;
         pb2_q     <= '0;
         y2_q      <= '0;
         g2_q      <= 1'b0;
         r3_q      <= '0;
         gs3_q     <= '0;
         b3_q      <= '0;
         y3_q      <= '0;
         g3_q      <= 1'b0;
         rgb4_q    <= '0;
         clip4_q   <= 1'b0;
         vs_q      <= '0;
         hs_q      <= '0;
         de_q      <= '0;
         vs_prev_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         cnt_vld_q <= 1'b0;
      end else begin
         y1_q      <= y1_d;
         cb1_q     <= cb1_d;
         cr1_q     <= cr1_d;
         g1_q      <= g1_d;
         yy2_q     <= yy2_d;
         pr2_q     <= pr2_d;
         pgb2_q    <= pgb2_d;
         pgr2_q    <= pgr2_d;
         pb2_q     <= pb2_d;
         y2_q      <= y2_d;
         g2_q      <= g2_d;
         r3_q      <= r3_d;
         gs3_q     <= gs3_d;
         b3_q      <= b3_d;
         y3_q      <= y3_d;
         g3_q      <= g3_d;
         rgb4_q    <= rgb4_d;
         clip4_q   <= clip4_d;
         vs_q      <= vs_d;
         hs_q      <= hs_d;
         de_q      <= de_d;
         vs_prev_q <= vs_prev_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         cnt_vld_q <= cnt_vld_d;
      end
   end

   assign bus.post_frame_vsync = vs_q[LAT-1];
   assign bus.post_frame_hsync = hs_q[LAT-1];
   assign bus.post_frame_de    = de_q[LAT-1];
   assign bus.rgb565_out       = rgb4_q;
   assign bus.clip_count       = cnt_q;
   assign bus.clip_count_valid = cnt_vld_q;
endmodule
